// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
`timescale 1ns/1ps
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered prefetch FIFO of {word, pc} entries; the head is read straight
// from storage, so a pushed entry becomes visible one cycle after the push.
`timescale 1ns/1ps
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  fetch_entry_t       push_data_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [CNT_W-1:0]   count_o,
  output fetch_entry_t       head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;

  // Flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the decoder-facing outputs start at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem request FSM, fetch PC tracking,
// prefetch FIFO towards the decoder and redirect/flush handling.
`timescale 1ns/1ps
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] code,
  output logic [31:0] code_pc,
  output logic        code_valid,
  input  logic        code_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      drop_addr_q, drop_addr_d;

  logic             push;
  logic             pop;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ_after_ack;
  logic             room_after_ack;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign pop        = code_valid && code_ready;
  assign code_valid = (count != '0);
  assign code       = head.word;
  assign code_pc    = head.pc;

  assign push_entry.word = imem_rdata;
  assign push_entry.pc   = fetch_pc_q;

  // Occupancy once this ack's word lands; decides back-to-back issue.
  assign occ_after_ack  = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
  assign room_after_ack = occ_after_ack < (CNT_W+1)'(DEPTH);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    push        = 1'b0;
    flush       = redirect;
    imem_req    = 1'b0;
    imem_addr   = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = align_word(redirect_pc);
          state_d    = REQ;
        end else if (count < CNT_W'(DEPTH)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          fetch_pc_d = align_word(redirect_pc);
          if (!imem_ack) begin
            // The old request is still in flight: keep presenting it.
            drop_addr_d = fetch_pc_q;
            state_d     = DROP;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
          state_d    = room_after_ack ? REQ : IDLE;
        end
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (redirect) fetch_pc_d = align_word(redirect_pc);
        if (imem_ack) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (count),
    .head_o      (head)
  );

endmodule
